// File: rtl/trace_capture_buffer_pkg.sv
// rtl/trace_capture_buffer_pkg.sv - shared encodings and field widths for the trace capture buffer
package trace_capture_buffer_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP       = 2'd0,
      MODE_STOP_FULL  = 2'd1,
      MODE_STOP_EVENT = 2'd2,
      MODE_RESERVED   = 2'd3
   } trace_mode_e;

   localparam logic [31:0] INST_NOP  = 32'h0000_0013;
   // jal x0,0 spins in place, so the core treats it as a halt
   localparam logic [31:0] INST_HALT = 32'h0000_006F;

   localparam int TRACE_INST_W = 32;

endpackage

// File: rtl/trace_capture_buffer_ram.sv
// rtl/trace_capture_buffer_ram.sv - trace entry storage, one write port and one registered read port
module trace_capture_buffer_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 80,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // read returns the pre-write contents when both ports hit one address
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/trace_capture_buffer.sv
// rtl/trace_capture_buffer.sv - retired-instruction trace recorder with halt, stall and timeout watchdog
module trace_capture_buffer
   import trace_capture_buffer_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter int          DEPTH       = 16,
   parameter int          CW          = 16,
   parameter int          TIMEOUT     = 100,
   parameter int          STALL_LIMIT = 8,
   parameter logic [31:0] HALT_INST   = INST_HALT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     clear,
   input  logic [1:0]               mode,
   input  logic                     trace_valid,
   input  logic [XLEN-1:0]          trace_pc,
   input  logic [31:0]              trace_inst,
   input  logic                     rd_req,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic                     rd_valid,
   output logic [XLEN-1:0]          rd_pc,
   output logic [31:0]              rd_inst,
   output logic [CW-1:0]            rd_cycle,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     frozen,
   output logic                     halted,
   output logic                     stalled,
   output logic                     timeout
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;
   localparam int IW   = $clog2(STALL_LIMIT + 1);
   localparam int EW   = CW + XLEN + TRACE_INST_W;

   localparam logic [CNTW-1:0] FULL_COUNT  = CNTW'(DEPTH);
   localparam logic [CNTW-1:0] LAST_COUNT  = CNTW'(DEPTH - 1);
   localparam logic [CW-1:0]   CYCLE_LIMIT = CW'(TIMEOUT);
   localparam logic [IW-1:0]   IDLE_LIMIT  = IW'(STALL_LIMIT);

   trace_mode_e     mode_e;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   wr_ptr_nxt;
   logic [CW-1:0]   cycle_cnt;
   logic [CW-1:0]   cycle_nxt;
   logic [IW-1:0]   idle_cnt;
   logic [IW-1:0]   idle_nxt;
   logic [CNTW-1:0] count_nxt;
   logic            overflow_nxt;
   logic            frozen_nxt;
   logic            halted_nxt;
   logic            stalled_nxt;
   logic            timeout_nxt;
   logic            full;
   logic            stop_full;
   logic            capture;
   logic            drop;
   logic [AW-1:0]   rd_addr;
   logic            rd_zero;
   logic            rd_zero_nxt;
   logic [EW-1:0]   wr_data;
   logic [EW-1:0]   rd_data;

   assign mode_e    = trace_mode_e'(mode);
   assign full      = (count == FULL_COUNT);
   assign stop_full = (mode_e == MODE_STOP_FULL);
   assign capture   = en && trace_valid && !frozen && !(stop_full && full);
   assign drop      = en && trace_valid && !capture;
   assign wr_data   = {cycle_cnt, trace_pc, trace_inst};

   // index 0 is the oldest live entry; count==DEPTH aliases to offset 0
   assign rd_addr     = wr_ptr - count[AW-1:0] + rd_idx;
   assign rd_zero_nxt = ({1'b0, rd_idx} >= count);

   always_comb begin
      cycle_nxt    = cycle_cnt;
      idle_nxt     = idle_cnt;
      wr_ptr_nxt   = wr_ptr;
      count_nxt    = count;
      overflow_nxt = overflow;
      frozen_nxt   = frozen;
      halted_nxt   = halted;
      stalled_nxt  = stalled;
      timeout_nxt  = timeout;

      if (en && !timeout) begin
         cycle_nxt = cycle_cnt + 1'b1;
      end
      if (cycle_nxt == CYCLE_LIMIT) begin
         timeout_nxt = 1'b1;
      end

      if (en) begin
         if (trace_valid) begin
            idle_nxt = '0;
         end else if (idle_cnt != IDLE_LIMIT) begin
            idle_nxt = idle_cnt + 1'b1;
         end
      end
      if (idle_nxt == IDLE_LIMIT) begin
         stalled_nxt = 1'b1;
      end

      if (capture) begin
         wr_ptr_nxt = wr_ptr + 1'b1;
         if (full) begin
            overflow_nxt = 1'b1;
         end else begin
            count_nxt = count + 1'b1;
         end
         if (stop_full && (count == LAST_COUNT)) begin
            frozen_nxt = 1'b1;
         end
         if (trace_inst == HALT_INST) begin
            halted_nxt = 1'b1;
         end
      end

      // a freeze caused by an event is expected, so its drops are not overflow
      if (drop) begin
         if (mode_e != MODE_STOP_EVENT) begin
            overflow_nxt = 1'b1;
         end
         if (stop_full) begin
            frozen_nxt = 1'b1;
         end
      end

      if ((mode_e == MODE_STOP_EVENT) &&
          ((halted_nxt && !halted) || (stalled_nxt && !stalled) || (timeout_nxt && !timeout))) begin
         frozen_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         cycle_cnt <= '0;
         idle_cnt  <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         frozen    <= 1'b0;
         halted    <= 1'b0;
         stalled   <= 1'b0;
         timeout   <= 1'b0;
         rd_valid  <= 1'b0;
         rd_zero   <= 1'b0;
      end else if (clear) begin
         wr_ptr    <= '0;
         cycle_cnt <= '0;
         idle_cnt  <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         frozen    <= 1'b0;
         halted    <= 1'b0;
         stalled   <= 1'b0;
         timeout   <= 1'b0;
         rd_valid  <= 1'b0;
         rd_zero   <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         cycle_cnt <= cycle_nxt;
         idle_cnt  <= idle_nxt;
         count     <= count_nxt;
         overflow  <= overflow_nxt;
         frozen    <= frozen_nxt;
         halted    <= halted_nxt;
         stalled   <= stalled_nxt;
         timeout   <= timeout_nxt;
         rd_valid  <= rd_req;
         rd_zero   <= rd_zero_nxt;
      end
   end

   trace_capture_buffer_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (capture && !clear),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (rd_req && !clear),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // storage is never reset, so the data bus is forced to zero unless a live entry was read
   assign {rd_cycle, rd_pc, rd_inst} = (rd_valid && !rd_zero) ? rd_data : '0;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb/tb_trace_capture_buffer.sv - scoreboard bench for the trace capture buffer
module tb_trace_capture_buffer;
   import trace_capture_buffer_pkg::*;

   localparam int DEPTH = 16;
   localparam int CW    = 16;
   localparam int XLEN  = 32;
   localparam int EW    = CW + XLEN + 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic              clear = 1'b0;
   logic [1:0]        mode = 2'd0;
   logic              trace_valid = 1'b0;
   logic [XLEN-1:0]   trace_pc = '0;
   logic [31:0]       trace_inst = '0;
   logic              rd_req = 1'b0;
   logic [3:0]        rd_idx = '0;
   logic              rd_valid;
   logic [XLEN-1:0]   rd_pc;
   logic [31:0]       rd_inst;
   logic [CW-1:0]     rd_cycle;
   logic [4:0]        count;
   logic              overflow, frozen, halted, stalled, timeout;

   always #5 clk = ~clk;

   trace_capture_buffer #(
      .XLEN(XLEN), .DEPTH(DEPTH), .CW(CW), .TIMEOUT(100), .STALL_LIMIT(8), .HALT_INST(INST_HALT)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode),
      .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_inst(trace_inst),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_pc(rd_pc),
      .rd_inst(rd_inst), .rd_cycle(rd_cycle), .count(count), .overflow(overflow),
      .frozen(frozen), .halted(halted), .stalled(stalled), .timeout(timeout)
   );

   int n_cmp = 0;
   int n_mis = 0;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] m_q[$];
   logic [EW-1:0] mon_e;
   int            m_cyc, m_idle;
   bit            m_frozen, m_ovf, m_halt, m_stall, m_to;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_cyc = 0; m_idle = 0;
      m_frozen = 0; m_ovf = 0; m_halt = 0; m_stall = 0; m_to = 0;
   endtask

   // queue-based reference: front of m_q is the oldest entry
   task automatic model_step(input bit v, input logic [31:0] pc, input logic [31:0] inst);
      bit full, cap, set_h, set_s, set_t;
      full = (m_q.size() == DEPTH);
      set_h = 0; set_s = 0; set_t = 0;
      cap = v && !m_frozen && !(mode == 2'd1 && full);
      if (v && !cap) begin
         if (mode != 2'd2) m_ovf = 1;
         if (mode == 2'd1) m_frozen = 1;
      end
      if (cap) begin
         if (full) begin
            void'(m_q.pop_front());
            m_ovf = 1;
         end
         m_q.push_back({CW'(m_cyc), pc, inst});
         if (mode == 2'd1 && m_q.size() == DEPTH) m_frozen = 1;
         if (inst == INST_HALT && !m_halt) set_h = 1;
      end
      if (!m_to) begin
         m_cyc++;
         if (m_cyc == 100) set_t = 1;
      end
      if (v) m_idle = 0;
      else if (m_idle < 8) m_idle++;
      if (m_idle == 8 && !m_stall) set_s = 1;
      m_halt  = m_halt | set_h;
      m_stall = m_stall | set_s;
      m_to    = m_to | set_t;
      if (mode == 2'd2 && (set_h || set_s || set_t)) m_frozen = 1;
   endtask

   task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] inst);
      en = 1'b1; trace_valid = v; trace_pc = pc; trace_inst = inst;
      model_step(v, pc, inst);
      @(posedge clk); #1;
      en = 1'b0; trace_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) cyc(1'b0, 32'h0, 32'h0);
   endtask

   task automatic do_clear(input bit v);
      en = 1'b1; clear = 1'b1; trace_valid = v; trace_pc = 32'h999; trace_inst = INST_NOP;
      @(posedge clk); #1;
      clear = 1'b0; trace_valid = 1'b0; en = 1'b0;
      model_reset();
   endtask

   task automatic rd_push(input logic [3:0] idx, input logic [EW-1:0] e);
      rd_req = 1'b1; rd_idx = idx;
      exp_q.push_back(e);
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic rd(input logic [3:0] idx);
      rd_push(idx, (int'(idx) < m_q.size()) ? m_q[idx] : '0);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_count"},    64'(count),    64'(m_q.size()));
      check({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
      check({tag, "_frozen"},   64'(frozen),   64'(m_frozen));
      check({tag, "_halted"},   64'(halted),   64'(m_halt));
      check({tag, "_stalled"},  64'(stalled),  64'(m_stall));
      check({tag, "_timeout"},  64'(timeout),  64'(m_to));
   endtask

   always @(negedge clk) begin
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            check("rd_pending", 64'(exp_q.size()), 64'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check("rd_cycle", 64'(rd_cycle), 64'(mon_e[EW-1 -: CW]));
            check("rd_pc",    64'(rd_pc),    64'(mon_e[63:32]));
            check("rd_inst",  64'(rd_inst),  64'(mon_e[31:0]));
         end
      end
   end

   initial begin
      model_reset();
      #12;
      check_state("reset");
      check("reset_rd_valid", 64'(rd_valid), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // wrap mode: 20 valids into 16 entries
      mode = 2'd0;
      do_clear(1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b1, 32'(i * 4), INST_NOP);
      check_state("wrap");
      check("wrap_count_const", 64'(count), 64'd16);
      check("wrap_overflow_const", 64'(overflow), 64'd1);
      rd_push(4'd0, {16'd4, 32'h10, INST_NOP});
      rd_push(4'd15, {16'd19, 32'h4C, INST_NOP});
      rd(4'd7);

      // stop-when-full
      mode = 2'd1;
      do_clear(1'b0);
      for (int i = 0; i < 15; i++) cyc(1'b1, 32'(i * 4), INST_NOP);
      check("sf_frozen_15", 64'(frozen), 64'd0);
      cyc(1'b1, 32'h3C, INST_NOP);
      check("sf_frozen_16", 64'(frozen), 64'd1);
      check("sf_ovf_16", 64'(overflow), 64'd0);
      cyc(1'b1, 32'h40, INST_NOP);
      cyc(1'b1, 32'h44, INST_NOP);
      check_state("stopfull");
      rd_push(4'd15, {16'd15, 32'h3C, INST_NOP});

      // stop-on-event via halt
      mode = 2'd2;
      do_clear(1'b0);
      cyc(1'b1, 32'h0, INST_NOP);
      cyc(1'b1, 32'h4, INST_NOP);
      cyc(1'b1, 32'h8, INST_NOP);
      cyc(1'b1, 32'hC, INST_HALT);
      check("halt_halted", 64'(halted), 64'd1);
      check("halt_frozen", 64'(frozen), 64'd1);
      cyc(1'b1, 32'h10, INST_NOP);
      cyc(1'b1, 32'h14, INST_NOP);
      check_state("halt");
      check("halt_count_const", 64'(count), 64'd4);
      rd_push(4'd3, {16'd3, 32'hC, INST_HALT});

      // stall then timeout in wrap mode
      mode = 2'd0;
      do_clear(1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'(i * 4), INST_NOP);
      idle_cycles(7);
      check("stall_at_7", 64'(stalled), 64'd0);
      idle_cycles(1);
      check("stall_at_8", 64'(stalled), 64'd1);
      idle_cycles(88);
      check("timeout_at_99", 64'(timeout), 64'd0);
      idle_cycles(1);
      check("timeout_at_100", 64'(timeout), 64'd1);
      cyc(1'b1, 32'h80, INST_NOP);
      check_state("timeout");
      check("timeout_frozen", 64'(frozen), 64'd0);
      rd_push(4'd3, {16'd100, 32'h80, INST_NOP});

      // out-of-range read, then clear racing a valid
      do_clear(1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'(i * 4), INST_NOP);
      rd_push(4'd7, '0);
      rd(4'd2);
      do_clear(1'b1);
      check_state("clear_wins");
      check("clear_count_const", 64'(count), 64'd0);

      // asynchronous reset in the middle of a cycle
      mode = 2'd2;
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), INST_NOP);
      cyc(1'b1, 32'h10, INST_HALT);
      check_state("pre_rst");
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_state("async_rst");
      check("async_rst_rd_valid", 64'(rd_valid), 64'd0);
      #3 rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
Synthesizable execution-trace recorder and watchdog for the RV32I core: records {cycle, pc, inst} for each retired instruction into a circular buffer of parametrised depth. Replaces the fixed cycle printout and fixed timeout of simulation-only benches, so traces exist on hardware and in any simulator. Sits beside the core, fed from the PC register and fetch data; read back via an indexed port by a debug host or bench.

Parameters:
XLEN, 32, pc width
DEPTH, 16, buffer entries; power of 2, >= 2
CW, 16, cycle-counter / timestamp width
TIMEOUT, 100, total enabled cycles before timeout flag; must be < 2^CW
STALL_LIMIT, 8, consecutive enabled cycles without trace_valid before stall flag
HALT_INST, 32'h0000006F, instruction pattern (jal x0,0) treated as halt

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  global enable; when 0 nothing counts or captures
clear  in  1  synchronous clear of buffer, counters, flags
mode  in  2  0=wrap, 1=stop-when-full, 2=stop-on-event, 3=reserved (behaves as 0)
trace_valid  in  1  instruction retired this cycle
trace_pc  in  XLEN  pc of retired instruction
trace_inst  in  32  retired instruction word
rd_req  in  1  read request
rd_idx  in  log2(DEPTH)  entry index, 0 = oldest valid entry
rd_valid  out  1  read data valid
rd_pc  out  XLEN  stored pc
rd_inst  out  32  stored instruction
rd_cycle  out  CW  stored timestamp
count  out  log2(DEPTH)+1  valid entries, 0..DEPTH
overflow  out  1  sticky: at least one entry overwritten or dropped
frozen  out  1  capture stopped
halted  out  1  sticky: HALT_INST captured
stalled  out  1  sticky: stall limit hit
timeout  out  1  sticky: TIMEOUT reached

Behaviour:
- Reset (async, rst=1): all outputs 0, wr_ptr=0, cycle_cnt=0, idle_cnt=0; storage contents don't-care. clear has the same effect on the next edge; clear wins over simultaneous capture.
- cycle_cnt: +1 per clock while en and !timeout; saturates at TIMEOUT; timeout sets when cycle_cnt reaches TIMEOUT.
- idle_cnt: 0 on any enabled trace_valid, else +1 while en; stalled sets when idle_cnt reaches STALL_LIMIT; idle_cnt saturates there.
- Capture: when en && trace_valid && !frozen: write {cycle_cnt, trace_pc, trace_inst} at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH; count = min(count+1, DEPTH). Timestamp is cycle_cnt before increment.
- Full (count==DEPTH) and capture in mode 0: oldest entry overwritten, overflow=1.
- Mode 1: count reaching DEPTH sets frozen on the same edge as the write; later valids dropped, overflow=1 on first dropped valid.
- Mode 2: frozen sets on the edge at which halted, stalled or timeout sets; the halting instruction itself is captured. Valids after freeze: dropped, no overflow.
- halted: sets when a captured inst == HALT_INST (all modes).
- frozen cleared only by clear or rst. en=0 while frozen: no change.
- Read: rd_req samples rd_idx; physical addr = (wr_ptr - count + rd_idx) mod DEPTH; data and rd_valid=1 on next cycle; rd_valid=0 otherwise. rd_idx >= count: rd_valid=1, data all zero. Read and write in the same cycle: read sees pre-write state.
- mode changes apply immediately; do not unfreeze.

Decomposition:
- Shared package/defines: trace mode encodings, default HALT_INST alongside existing INST_NOP define, trace-entry field widths.
- One sub-module: trace_ram (DEPTH x (CW+XLEN+32), 1 write port, 1 registered read port). Counters, flags, pointer logic in the top.

Test Plan:
- Reset mid-run: 5 captures, assert rst asynchronously mid-cycle -> count=0, all flags 0 immediately, before next edge.
- Mode 0, DEPTH=16: 20 consecutive valids, pc=0x00..0x4C step 4 -> count=16, overflow=1, rd_idx=0 returns pc=0x10, rd_cycle=4; rd_idx=15 returns pc=0x4C.
- Mode 1: 18 valids -> frozen after 16th, count=16, rd_idx=15 pc=0x3C, overflow=1.
- Mode 2 halt: NOPs (0x00000013) at pc 0,4,8 then 0x0000006F at pc 0xC -> halted=1, frozen=1, count=4, later valids ignored.
- Stall/timeout: 3 valids then trace_valid=0 -> stalled=1 exactly 8 cycles after last valid; run to cycle 100 -> timeout=1, cycle_cnt holds 100.
- rd_idx=7 with count=3 -> rd_valid=1 next cycle, data zero; clear with simultaneous valid -> count=0.
